// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types and defaults for the multiplier-sharing controller
package mul_share_pkg;

  localparam int LEN_DEF  = 16;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mul_share_ctrl_rr_pick.sv
// rtl/mul_share_ctrl_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PTRW-1:0] idx
);

  logic [PTRW-1:0] cand;

  // Walk from the farthest slot back toward ptr so the nearest set bit wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTRW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin front end sharing one sequential multiplier
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int LEN  = LEN_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ_VALID,
  output logic [NREQ-1:0]     REQ_READY,
  input  logic [NREQ*LEN-1:0] REQ_A,
  input  logic [NREQ*LEN-1:0] REQ_B,
  output logic [NREQ-1:0]     RSP_VALID,
  input  logic [NREQ-1:0]     RSP_READY,
  output logic [LEN-1:0]      RSP_Y,
  output logic                MUL_START,
  output logic [LEN-1:0]      MUL_A,
  output logic [LEN-1:0]      MUL_B,
  input  logic                MUL_DONE,
  input  logic [LEN-1:0]      MUL_Y
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   grant_q, grant_d;
  logic [LEN-1:0]    mul_a_q, mul_a_d;
  logic [LEN-1:0]    mul_b_q, mul_b_d;
  logic [LEN-1:0]    rsp_y_q, rsp_y_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [PTRW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    rsp_y_d   = rsp_y_q;
    REQ_READY = '0;
    RSP_VALID = '0;
    MUL_START = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|REQ_VALID) begin
          REQ_READY = pick_gnt;
          grant_d   = pick_idx;
          mul_a_d   = REQ_A[pick_idx*LEN +: LEN];
          mul_b_d   = REQ_B[pick_idx*LEN +: LEN];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        MUL_START = 1'b1;
        state_d   = WAIT;
      end
      // DONE outside this state belongs to the previous job and is never looked at.
      WAIT: begin
        if (MUL_DONE) begin
          rsp_y_d = MUL_Y;
          state_d = RESP;
        end
      end
      RESP: begin
        RSP_VALID[grant_q] = 1'b1;
        if (RSP_READY[grant_q]) begin
          state_d = IDLE;
          ptr_d   = (grant_q == PTRW'(NREQ - 1)) ? '0 : grant_q + PTRW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      rsp_y_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      rsp_y_q <= rsp_y_d;
    end
  end

  assign MUL_A = mul_a_q;
  assign MUL_B = mul_b_q;
  assign RSP_Y = rsp_y_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl with a digit-serial multiplier stand-in
module tb_mul_share_ctrl;

  localparam int LEN  = 16;
  localparam int NREQ = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     REQ_VALID;
  logic [NREQ-1:0]     REQ_READY;
  logic [NREQ*LEN-1:0] REQ_A;
  logic [NREQ*LEN-1:0] REQ_B;
  logic [NREQ-1:0]     RSP_VALID;
  logic [NREQ-1:0]     RSP_READY;
  logic [LEN-1:0]      RSP_Y;
  logic                MUL_START;
  logic [LEN-1:0]      MUL_A;
  logic [LEN-1:0]      MUL_B;
  logic                MUL_DONE = 1'b1;
  logic [LEN-1:0]      MUL_Y = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mul_share_ctrl #(.LEN(LEN), .NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_Y     (RSP_Y),
    .MUL_START (MUL_START),
    .MUL_A     (MUL_A),
    .MUL_B     (MUL_B),
    .MUL_DONE  (MUL_DONE),
    .MUL_Y     (MUL_Y)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: not reset, DONE stays high after a job, extra cycles
  // grow with the number of significant radix-4 digits of B.
  function automatic int mul_delay(input logic [15:0] a, input logic [15:0] b);
    int nd;
    nd = 0;
    if (a == 16'd0 || b == 16'd0) return 0;
    for (int i = 0; i < 8; i++) if (b[2*i +: 2] != 2'd0) nd = i + 1;
    return (nd + 1) / 2;
  endfunction

  int mul_cnt = 0;
  always @(posedge CLK) begin
    if (MUL_START) begin
      MUL_Y    <= MUL_A * MUL_B;
      mul_cnt  <= mul_delay(MUL_A, MUL_B);
      MUL_DONE <= (mul_delay(MUL_A, MUL_B) == 0);
    end else if (!MUL_DONE) begin
      if (mul_cnt <= 1) MUL_DONE <= 1'b1;
      mul_cnt <= mul_cnt - 1;
    end
  end

  // Reference model: tracks the one job in flight by cycle numbers.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  int          cyc = 0;
  bit          m_live = 0, m_busy = 0, m_rv = 0;
  int          m_g = 0, m_acc = 0, m_ptr = 0;
  logic [15:0] m_mula = 0, m_mulb = 0, m_rspy = 0;
  int          pg;

  always @(posedge CLK) begin
    if (RST) begin
      m_live <= 1; m_busy <= 0; m_rv <= 0; m_ptr <= 0;
      m_mula <= 0; m_mulb <= 0; m_rspy <= 0;
    end else if (m_live) begin
      if (!m_busy) begin
        pg = pick(REQ_VALID, m_ptr);
        if (pg >= 0) begin
          m_busy <= 1; m_rv <= 0; m_g <= pg; m_acc <= cyc;
          m_mula <= REQ_A[pg*LEN +: LEN];
          m_mulb <= REQ_B[pg*LEN +: LEN];
        end
      end else if (!m_rv) begin
        if (cyc >= m_acc + 2 && MUL_DONE) begin
          m_rv   <= 1;
          m_rspy <= m_mula * m_mulb;
        end
      end else if (RSP_READY[m_g]) begin
        m_busy <= 0;
        m_ptr  <= (m_g + 1) % NREQ;
      end
    end
    cyc <= cyc + 1;
  end

  logic [NREQ-1:0] exp_rdy, exp_rv;
  logic            exp_st;
  logic            prev_start = 1'b0;
  int              cg;

  always @(negedge CLK) begin
    if (m_live && !RST) begin
      exp_rdy = '0; exp_rv = '0; exp_st = 1'b0;
      if (!m_busy) begin
        cg = pick(REQ_VALID, m_ptr);
        if (cg >= 0) exp_rdy[cg] = 1'b1;
      end else begin
        exp_st = (cyc == m_acc + 1);
        if (m_rv) exp_rv[m_g] = 1'b1;
      end
      chk("m_req_ready", 32'(REQ_READY), 32'(exp_rdy));
      chk("m_rsp_valid", 32'(RSP_VALID), 32'(exp_rv));
      chk("m_mul_start", 32'(MUL_START), 32'(exp_st));
      chk("m_mul_a", 32'(MUL_A), 32'(m_mula));
      chk("m_mul_b", 32'(MUL_B), 32'(m_mulb));
      chk("m_rsp_y", 32'(RSP_Y), 32'(m_rspy));
      chk("start_twice", 32'(MUL_START & prev_start), 32'd0);
    end
    prev_start = MUL_START;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    REQ_A[i*LEN +: LEN] = a;
    REQ_B[i*LEN +: LEN] = b;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(REQ_READY), 32'd0);
    chk({nm, "_valid"}, 32'(RSP_VALID), 32'd0);
    chk({nm, "_start"}, 32'(MUL_START), 32'd0);
    chk({nm, "_a"}, 32'(MUL_A), 32'd0);
    chk({nm, "_b"}, 32'(MUL_B), 32'd0);
    chk({nm, "_y"}, 32'(RSP_Y), 32'd0);
  endtask

  // Single-requester job; latency counted from the accept cycle to first RSP_VALID.
  task automatic job(input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] expy, input int exp_lat);
    int lat;
    step();
    set_req(i, a, b);
    REQ_VALID = 4'(1 << i);
    @(negedge CLK);
    chk("accept_ready", 32'(REQ_READY), 32'(1 << i));
    step();
    REQ_VALID = '0;
    @(negedge CLK);
    chk("issue_start", 32'(MUL_START), 32'd1);
    lat = 1;
    while (RSP_VALID == '0 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_valid", 32'(RSP_VALID), 32'(1 << i));
    chk("rsp_y", 32'(RSP_Y), 32'(expy));
    #1 RSP_READY = 4'(1 << i);
    step();
    RSP_READY = '0;
    @(negedge CLK);
    chk("rsp_drop", 32'(RSP_VALID), 32'd0);
  endtask

  int          rr_ord[5] = '{0, 1, 2, 3, 0};
  logic [15:0] rr_y[5]   = '{16'd14, 16'h0000, 16'h0001, 16'h1234, 16'd14};
  int          w;

  initial begin
    RST = 1'b1; REQ_VALID = '0; RSP_READY = '0; REQ_A = '0; REQ_B = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("reset");

    job(0, 16'd3, 16'd5, 16'd15, 4);
    job(2, 16'd0, 16'hBEEF, 16'd0, 3);

    // Round-robin from a fresh ptr with all requesters pending.
    step(); RST = 1'b1;
    step(); RST = 1'b0;
    set_req(0, 16'd2, 16'd7);
    set_req(1, 16'h0100, 16'h0100);
    set_req(2, 16'hFFFF, 16'hFFFF);
    set_req(3, 16'h1234, 16'h0001);
    REQ_VALID = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      @(negedge CLK);
      while (RSP_VALID == '0 && w < 40) begin
        @(negedge CLK);
        w++;
      end
      chk("rr_grant", 32'(RSP_VALID), 32'(1 << rr_ord[k]));
      chk("rr_y", 32'(RSP_Y), 32'(rr_y[k]));
      #1 RSP_READY = 4'(1 << rr_ord[k]);
      @(posedge CLK);
      #1 RSP_READY = '0;
      if (k == 4) REQ_VALID = '0;
    end

    // Backpressure: ptr is 1, requester 1 gets the job while 3 waits.
    set_req(1, 16'd6, 16'd7);
    step();
    REQ_VALID = 4'b0010;
    @(negedge CLK);
    #1 REQ_VALID = 4'b1010;
    w = 0;
    while (RSP_VALID == '0 && w < 40) begin
      @(negedge CLK);
      w++;
    end
    for (int j = 0; j < 10; j++) begin
      chk("bp_valid", 32'(RSP_VALID), 32'b0010);
      chk("bp_y", 32'(RSP_Y), 32'd42);
      chk("bp_ready", 32'(REQ_READY), 32'd0);
      chk("bp_start", 32'(MUL_START), 32'd0);
      if (j < 9) @(negedge CLK);
    end
    #1 RSP_READY = 4'b0010;
    @(posedge CLK);
    #1 RSP_READY = '0;
    @(negedge CLK);
    chk("bp_resume", 32'(REQ_READY), 32'b1000);
    step();
    REQ_VALID = '0;
    w = 0;
    while (RSP_VALID == '0 && w < 40) begin
      @(negedge CLK);
      w++;
    end
    chk("bp_next_y", 32'(RSP_Y), 32'h1234);
    #1 RSP_READY = 4'b1000;
    step();
    RSP_READY = '0;

    // Reset during WAIT abandons the job; the stale DONE of that job arrives during the next ISSUE.
    step();
    set_req(0, 16'hFFFF, 16'hFFFF);
    REQ_VALID = 4'b0001;
    step(); REQ_VALID = '0;
    step();
    step(); RST = 1'b1;
    step(); RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("abort");
    job(2, 16'd9, 16'd9, 16'd81, 4);

    // DONE is already high from the previous job when this one issues.
    chk("stale_done_high", 32'(MUL_DONE), 32'd1);
    job(0, 16'h00FF, 16'h0101, 16'hFFFF, 6);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
